alu_bcd_display: RTL and testbench

- Display back-end directly downstream of the 4-bit ALU top; consumes its 12-bit BCD result plus the carry_out, overflow and error flags.
- Snapshots the result on a load strobe and time-multiplexes four common-anode 7-segment digits.
- Shows three BCD digits with leading-zero blanking, a carry indicator and an overflow decimal point; shows "Err" on error.
- Sits between the ALU and the board's seven-segment pins.

---
 rtl/alu_disp_pkg.sv | 47 ++++
 rtl/alu_bcd_display_seg7_decode.sv | 11 +
 rtl/alu_bcd_display.sv | 154 +++++++++++++++
 tb/tb_alu_bcd_display.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_disp_pkg.sv
// Shared glyph constants, digit-index type and BCD-to-segment helper for the
// ALU seven-segment display back-end. All glyphs are active-low {g,f,e,d,c,b,a}.
package alu_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_t;

    // Non-decimal nibbles map to a dash so a corrupt result is visible.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] glyph;
        case (nib)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_DASH;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/alu_bcd_display_seg7_decode.sv
// Combinational nibble-to-segment decoder; values above 9 render as a dash.
module seg7_decode
    import alu_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = bcd_to_seg(nib);

endmodule

// File: rtl/alu_bcd_display.sv
// Snapshots the ALU BCD result and flags on load, then scans four
// common-anode digits: carry 'C', three BCD digits with blanking, or "Err".
module alu_bcd_display
    import alu_disp_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int CNT_W   = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [11:0] bcd,
    input  logic        error,
    input  logic        carry_out,
    input  logic        overflow,
    input  logic        display_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done,
    output logic        bad_bcd
);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             wrap;
    digit_t           state_reg, state_next;

    logic [11:0]      snap_bcd_reg;
    logic             snap_err_reg, snap_carry_reg, snap_ovf_reg;
    logic             bad_reg;
    logic [2:0]       in_nib_bad;

    logic [3:0]       nib;
    logic [6:0]       dec_seg;
    logic             hund_zero, tens_zero;

    logic [3:0]       an_reg, an_next;
    logic [6:0]       seg_reg, seg_next;
    logic             dp_reg, dp_next;
    logic             fd_reg, fd_next;

    // Refresh counter: each digit stays lit for CLK_DIV cycles.
    assign wrap     = (cnt_reg == CNT_W'(CLK_DIV - 1));
    assign cnt_next = wrap ? '0 : cnt_reg + CNT_W'(1);

    always_comb begin
        state_next = state_reg;
        if (wrap) begin
            case (state_reg)
                DIG0:    state_next = DIG1;
                DIG1:    state_next = DIG2;
                DIG2:    state_next = DIG3;
                DIG3:    state_next = DIG0;
                default: state_next = DIG0;
            endcase
        end
    end

    assign fd_next = wrap && (state_reg == DIG3);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_nib_chk
            assign in_nib_bad[gi] = (bcd[4*gi +: 4] > 4'd9);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            state_reg      <= DIG0;
            snap_bcd_reg   <= '0;
            snap_err_reg   <= 1'b0;
            snap_carry_reg <= 1'b0;
            snap_ovf_reg   <= 1'b0;
            bad_reg        <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            state_reg <= state_next;
            if (load) begin
                snap_bcd_reg   <= bcd;
                snap_err_reg   <= error;
                snap_carry_reg <= carry_out;
                snap_ovf_reg   <= overflow;
                bad_reg        <= |in_nib_bad;
            end
        end
    end

    // Single decoder shared across digits; the current digit picks its nibble.
    always_comb begin
        nib = snap_bcd_reg[3:0];
        case (state_reg)
            DIG0:    nib = snap_bcd_reg[3:0];
            DIG1:    nib = snap_bcd_reg[7:4];
            DIG2:    nib = snap_bcd_reg[11:8];
            default: nib = snap_bcd_reg[3:0];
        endcase
    end

    seg7_decode u_decode (
        .nib (nib),
        .seg (dec_seg)
    );

    assign hund_zero = (snap_bcd_reg[11:8] == 4'd0);
    assign tens_zero = (snap_bcd_reg[7:4] == 4'd0);

    always_comb begin
        seg_next = SEG_BLANK;
        if (snap_err_reg) begin
            case (state_reg)
                DIG3:    seg_next = SEG_BLANK;
                DIG2:    seg_next = SEG_E;
                default: seg_next = SEG_R;
            endcase
        end else begin
            case (state_reg)
                DIG0:    seg_next = dec_seg;
                DIG1:    seg_next = (hund_zero && tens_zero) ? SEG_BLANK : dec_seg;
                DIG2:    seg_next = hund_zero ? SEG_BLANK : dec_seg;
                default: seg_next = snap_carry_reg ? SEG_C : SEG_BLANK;
            endcase
        end
    end

    assign dp_next = !((state_reg == DIG0) && !snap_err_reg && snap_ovf_reg);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_anode
            assign an_next[gi] = !(display_en && (state_reg == digit_t'(2'(gi))));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_reg  <= 4'b1111;
            seg_reg <= SEG_BLANK;
            dp_reg  <= 1'b1;
            fd_reg  <= 1'b0;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
            fd_reg  <= fd_next;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign frame_done = fd_reg;
    assign bad_bcd    = bad_reg;

endmodule

// File: tb/tb_alu_bcd_display.sv
// Self-checking bench for alu_bcd_display: directed test-plan steps followed by
// randomized loads, enables and resets, all compared against a cycle-count model.
module tb_alu_bcd_display;

    localparam int CLK_DIV = 4;
    localparam int CNT_W   = 3;
    localparam int FRAME   = 4 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [11:0] bcd;
    logic        error;
    logic        carry_out;
    logic        overflow;
    logic        display_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;
    logic        bad_bcd;

    alu_bcd_display #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bcd        (bcd),
        .error      (error),
        .carry_out  (carry_out),
        .overflow   (overflow),
        .display_en (display_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done),
        .bad_bcd    (bad_bcd)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: edges since reset release plus the captured snapshot.
    int          m_n;
    logic [11:0] m_bcd;
    logic        m_err, m_cy, m_ov, m_bad;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd, e_bad;

    function automatic logic [6:0] glyph(int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [6:0] want_seg(int pos);
        int h, t, u;
        h = int'(m_bcd[11:8]);
        t = int'(m_bcd[7:4]);
        u = int'(m_bcd[3:0]);
        if (m_err) begin
            if (pos == 3) return 7'h7F;
            if (pos == 2) return 7'b0000110;
            return 7'b0101111;
        end
        case (pos)
            0: return glyph(u);
            1: return (h == 0 && t == 0) ? 7'h7F : glyph(t);
            2: return (h == 0) ? 7'h7F : glyph(h);
            default: return m_cy ? 7'b1000110 : 7'h7F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] want);
        n_vec++;
        assert (got === want)
        else begin
            n_fail++;
            $error("FAIL %s t=%0t got=%b want=%b", tag, $time, got, want);
        end
    endtask

    // One clock: predict from pre-edge model state, advance the model, then
    // compare all outputs on the falling edge.
    task automatic step();
        int idx;
        if (!rst_n) begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
            e_fd  = 1'b0;
            e_bad = 1'b0;
            m_n   = 0;
            m_bcd = '0;
            m_err = 1'b0;
            m_cy  = 1'b0;
            m_ov  = 1'b0;
            m_bad = 1'b0;
        end else begin
            idx   = (m_n / CLK_DIV) % 4;
            e_an  = display_en ? ~(4'b0001 << idx) : 4'hF;
            e_seg = want_seg(idx);
            e_dp  = (idx == 0 && !m_err && m_ov) ? 1'b0 : 1'b1;
            e_fd  = ((m_n + 1) % FRAME) == 0;
            m_n++;
            if (load) begin
                m_bcd = bcd;
                m_err = error;
                m_cy  = carry_out;
                m_ov  = overflow;
                m_bad = (bcd[11:8] > 9) || (bcd[7:4] > 9) || (bcd[3:0] > 9);
            end
            e_bad = m_bad;
        end
        @(posedge clk);
        @(negedge clk);
        check("an",         7'(an),         7'(e_an));
        check("seg",        seg,            e_seg);
        check("dp",         7'(dp),         7'(e_dp));
        check("frame_done", 7'(frame_done), 7'(e_fd));
        check("bad_bcd",    7'(bad_bcd),    7'(e_bad));
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(logic [11:0] v, logic e, logic c, logic o);
        bcd = v; error = e; carry_out = c; overflow = o;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    int first_fd;

    initial begin
        rst_n = 1'b0; load = 1'b0; bcd = '0; error = 1'b0;
        carry_out = 1'b0; overflow = 1'b0; display_en = 1'b1;
        m_n = 0; m_bcd = '0; m_err = 0; m_cy = 0; m_ov = 0; m_bad = 0;
        @(negedge clk);

        run(3);
        rst_n = 1'b1;

        // First frame_done expected 16 edges after release.
        first_fd = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (frame_done && first_fd < 0) first_fd = i;
        end
        check("first_fd_cycle", 7'(first_fd), 7'(FRAME));

        do_load(12'h125, 1'b0, 1'b1, 1'b0);
        run(2 * FRAME);
        do_load(12'h007, 1'b0, 1'b0, 1'b1);
        run(2 * FRAME);
        do_load(12'h999, 1'b1, 1'b0, 1'b0);
        run(2 * FRAME);
        do_load(12'h0A3, 1'b0, 1'b0, 1'b0);
        run(2 * FRAME);

        // Blank mid-frame, then resume.
        run(5);
        display_en = 1'b0;
        run(9);
        display_en = 1'b1;
        run(FRAME);

        // Load coincident with the 3->0 wrap edge.
        for (int i = 0; i < FRAME && (m_n % FRAME) != FRAME - 1; i++) step();
        check("wrap_align", 7'(m_n % FRAME), 7'(FRAME - 1));
        do_load(12'h042, 1'b0, 1'b0, 1'b0);
        check("wrap_fd", 7'(frame_done), 7'd1);
        run(2 * FRAME);

        // Back-to-back loads: last wins.
        bcd = 12'h311; load = 1'b1; step();
        bcd = 12'h058; step();
        load = 1'b0;
        run(FRAME);

        // Load during reset is ignored.
        rst_n = 1'b0;
        do_load(12'h777, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
        run(FRAME);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bcd       = 12'($urandom);
                error     = ($urandom_range(0, 5) == 0);
                carry_out = 1'($urandom);
                overflow  = 1'($urandom);
                load      = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 19) == 0) display_en = ~display_en;
            rst_n = ($urandom_range(0, 149) != 0);
            step();
        end
        load = 1'b0; rst_n = 1'b1; display_en = 1'b1;
        run(FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
